// File: rtl/imem_line_server_pkg.sv
// Shared definitions for imem_line_server: sequencer state encoding and the
// supported backing-memory latency range.
package imem_line_server_pkg;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } seq_state_t;

    localparam int MEM_LATENCY_MIN = 1;
    localparam int MEM_LATENCY_MAX = 4;

endpackage

// File: rtl/imem_req_fifo.sv
// Registered FIFO holding line addresses of accepted-but-unstarted requests.
// Push and pop may happen on the same edge; DEPTH must be a power of two.
module imem_req_fifo #(
    parameter int WIDTH = 25,
    parameter int DEPTH = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);

    localparam int PTR_BITS = $clog2(DEPTH);
    localparam logic [PTR_BITS:0] FULL_COUNT = DEPTH[PTR_BITS:0];

    logic [WIDTH-1:0]    slots [DEPTH];
    logic [PTR_BITS-1:0] wr_ptr;
    logic [PTR_BITS-1:0] rd_ptr;
    logic [PTR_BITS:0]   count;
    logic                do_push;
    logic                do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign empty   = (count == '0);
    assign full    = (count == FULL_COUNT);
    assign head    = slots[rd_ptr];

    // Pointer and occupancy bookkeeping.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage.
    // NOTE: storage is not reset; the occupancy count guarantees stale slots are never read as valid.
    always_ff @(posedge clock) begin
        if (do_push) slots[wr_ptr] <= din;
    end

endmodule

// File: rtl/imem_line_server.sv
// Line-burst read responder for the instruction fetch port. Each accepted
// request returns one full line, word 0 first, through a fixed-latency
// backing memory. Optional performance counters are built only when
// IMEM_LINE_SERVER_PERF_EN is defined.
module imem_line_server
    import imem_line_server_pkg::*;
#(
    parameter int WORD_INDEX_BITS = 5,
    parameter int ADDR_BITS       = 30,
    parameter int MEM_LATENCY     = 2,
    parameter int QUEUE_DEPTH     = 2
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [ADDR_BITS-1:0] imem_address,
    input  logic                 imem_read,
    output logic                 imem_waitrequest,
    output logic [31:0]          imem_readdata,
    output logic                 imem_readdatavalid,
    output logic [ADDR_BITS-1:0] mem_address,
    output logic                 mem_read,
    input  logic [31:0]          mem_rddata,
    output logic [31:0]          perf_bursts,
    output logic [31:0]          perf_wait_cycles
);

    localparam int LINE_BITS = ADDR_BITS - WORD_INDEX_BITS;
    // Latencies outside the supported range are clamped to the nearest limit.
    localparam int LAT = (MEM_LATENCY < MEM_LATENCY_MIN) ? MEM_LATENCY_MIN :
                         (MEM_LATENCY > MEM_LATENCY_MAX) ? MEM_LATENCY_MAX : MEM_LATENCY;

    seq_state_t                 state;
    seq_state_t                 state_next;
    logic [LINE_BITS-1:0]       base;
    logic [LINE_BITS-1:0]       base_next;
    logic [LINE_BITS-1:0]       head;
    logic [LINE_BITS-1:0]       issue_line;
    logic [WORD_INDEX_BITS-1:0] wi;
    logic [WORD_INDEX_BITS-1:0] wi_next;
    logic [WORD_INDEX_BITS-1:0] issue_wi;
    logic                       fifo_empty;
    logic                       fifo_full;
    logic                       push;
    logic                       pop;
    logic                       issue;
    logic [LAT-1:0]             valid_pipe;
    logic                       unused_addr_bits;

    // The word offset of a request is ignored; the burst always starts at word 0.
    assign unused_addr_bits = ^imem_address[WORD_INDEX_BITS-1:0];

    assign imem_waitrequest   = fifo_full;
    assign push               = imem_read & ~fifo_full;
    assign imem_readdata      = mem_rddata;
    assign imem_readdatavalid = valid_pipe[LAT-1];

    imem_req_fifo #(
        .WIDTH (LINE_BITS),
        .DEPTH (QUEUE_DEPTH)
    ) u_req_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .din     (imem_address[ADDR_BITS-1:WORD_INDEX_BITS]),
        .head    (head),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    // Sequencer: pick the word to issue this cycle and where the burst goes next.
    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
        state_next = state;
        base_next  = base;
        wi_next    = wi;
        pop        = 1'b0;
        issue      = 1'b0;
        issue_line = base;
        issue_wi   = wi;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    // Word 0 goes out on the same edge the request is popped.
                    pop        = 1'b1;
                    issue      = 1'b1;
                    issue_line = head;
                    issue_wi   = '0;
                    base_next  = head;
                    wi_next    = WORD_INDEX_BITS'(1);
                    state_next = S_BURST;
                end
            end
            S_BURST: begin
                issue   = 1'b1;
                wi_next = wi + 1'b1;
                if (&wi) begin
                    if (!fifo_empty) begin
                        // Chain straight into the next line; wi wraps to 0.
                        pop       = 1'b1;
                        base_next = head;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Sequencer state and registered backing-memory strobe/address.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            base        <= '0;
            wi          <= '0;
            mem_read    <= 1'b0;
            mem_address <= '0;
        end else begin
            state    <= state_next;
            base     <= base_next;
            wi       <= wi_next;
            mem_read <= issue;
            if (issue) mem_address <= {issue_line, issue_wi};
        end
    end

    // Return-path valid tracking: the strobe delayed by the memory latency.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) valid_pipe <= '0;
        else          valid_pipe <= (valid_pipe << 1) | LAT'(mem_read);
    end

`ifdef IMEM_LINE_SERVER_PERF_EN
    logic [WORD_INDEX_BITS-1:0] ret_wi;
    logic [31:0]                bursts_q;
    logic [31:0]                waits_q;

    // Count completed lines on the return side and stalled request cycles.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ret_wi   <= '0;
            bursts_q <= '0;
            waits_q  <= '0;
        end else begin
            if (imem_readdatavalid) begin
                ret_wi <= ret_wi + 1'b1;
                if (&ret_wi) bursts_q <= bursts_q + 32'd1;
            end
            if (imem_read && imem_waitrequest) waits_q <= waits_q + 32'd1;
        end
    end

    assign perf_bursts      = bursts_q;
    assign perf_wait_cycles = waits_q;
`else
    assign perf_bursts      = '0;
    assign perf_wait_cycles = '0;
`endif

endmodule

// File: tb/tb_imem_line_server.sv
// Bench for imem_line_server. Three instances (memory latency 2, 1 and 4)
// share the request stimulus; each has its own backing memory model. A
// request-level reference model predicts acceptance, burst start times and
// the returned word stream.
`timescale 1ns/1ps
module tb_imem_line_server;

    localparam int WIB   = 5;
    localparam int AB    = 30;
    localparam int W     = 1 << WIB;
    localparam int DEPTH = 2;
    localparam int NL    = 3;
    localparam int OBS_MAX = 4096;

`ifdef IMEM_LINE_SERVER_PERF_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset_n;
    logic [AB-1:0] imem_address;
    logic          imem_read;

    logic          wr   [NL];
    logic [31:0]   rdd  [NL];
    logic          rdv  [NL];
    logic [AB-1:0] maddr[NL];
    logic          mread[NL];
    logic [31:0]   mrd  [NL];
    logic [31:0]   pb   [NL];
    logic [31:0]   pw   [NL];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    imem_line_server #(.WORD_INDEX_BITS(WIB), .ADDR_BITS(AB), .MEM_LATENCY(2), .QUEUE_DEPTH(DEPTH)) dut (
        .clock(clock), .reset_n(reset_n), .imem_address(imem_address), .imem_read(imem_read),
        .imem_waitrequest(wr[0]), .imem_readdata(rdd[0]), .imem_readdatavalid(rdv[0]),
        .mem_address(maddr[0]), .mem_read(mread[0]), .mem_rddata(mrd[0]),
        .perf_bursts(pb[0]), .perf_wait_cycles(pw[0]));

    imem_line_server #(.WORD_INDEX_BITS(WIB), .ADDR_BITS(AB), .MEM_LATENCY(1), .QUEUE_DEPTH(DEPTH)) dut_l1 (
        .clock(clock), .reset_n(reset_n), .imem_address(imem_address), .imem_read(imem_read),
        .imem_waitrequest(wr[1]), .imem_readdata(rdd[1]), .imem_readdatavalid(rdv[1]),
        .mem_address(maddr[1]), .mem_read(mread[1]), .mem_rddata(mrd[1]),
        .perf_bursts(pb[1]), .perf_wait_cycles(pw[1]));

    imem_line_server #(.WORD_INDEX_BITS(WIB), .ADDR_BITS(AB), .MEM_LATENCY(4), .QUEUE_DEPTH(DEPTH)) dut_l4 (
        .clock(clock), .reset_n(reset_n), .imem_address(imem_address), .imem_read(imem_read),
        .imem_waitrequest(wr[2]), .imem_readdata(rdd[2]), .imem_readdatavalid(rdv[2]),
        .mem_address(maddr[2]), .mem_read(mread[2]), .mem_rddata(mrd[2]),
        .perf_bursts(pb[2]), .perf_wait_cycles(pw[2]));

    function automatic int lat_of(input int l);
        return (l == 0) ? 2 : ((l == 1) ? 1 : 4);
    endfunction

    // Backing memory contents: a fixed scramble of the word address.
    function automatic logic [31:0] mem_fn(input logic [AB-1:0] a);
        return {a, 2'b01} ^ (32'h9E3779B9 * {2'b00, a});
    endfunction

    // Backing memories: address sampled at the edge, data appears latency-1 edges later.
    logic [AB-1:0] apipe [NL][4];
    always @(posedge clock) begin
        for (int l = 0; l < NL; l++) begin
            for (int i = 3; i > 0; i--) apipe[l][i] <= apipe[l][i-1];
            apipe[l][0] <= maddr[l];
        end
    end
    assign mrd[0] = mem_fn(apipe[0][1]);
    assign mrd[1] = mem_fn(apipe[1][0]);
    assign mrd[2] = mem_fn(apipe[2][3]);

    // Edge counter: at a falling edge, cyc is the number of rising edges seen.
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Output monitor: log every returned word with the edge it followed.
    int          obs_n   [NL];
    int          obs_cyc [NL][OBS_MAX];
    logic [31:0] obs_dat [NL][OBS_MAX];
    initial for (int l = 0; l < NL; l++) obs_n[l] = 0;
    always @(negedge clock) begin
        for (int l = 0; l < NL; l++) begin
            if (rdv[l] === 1'b1 && obs_n[l] < OBS_MAX) begin
                obs_cyc[l][obs_n[l]] = cyc;
                obs_dat[l][obs_n[l]] = rdd[l];
                obs_n[l] = obs_n[l] + 1;
            end
        end
    end

    // Reference model: accepted requests since the last reset.
    logic [AB-WIB-1:0] acc_line [64];
    int                acc_edge [64];
    int                pop_edge [64];
    int                acc_start[64];
    int                n_req       = 0;
    int                last_start  = -1000;
    int                model_waits = 0;
    int                wr_bad      = 0;
    int                req_base    = 0;
    int                obs_base [NL];

    logic [AB-1:0]     req_addr [16];
    int                req_gap  [16];

    // Requests queued (accepted, not yet started) after edge e.
    function automatic int occupancy(input int e);
        int occ = 0;
        for (int r = 0; r < n_req; r++) begin
            if (acc_edge[r] <= e) occ++;
            if (pop_edge[r] <= e) occ--;
        end
        return occ;
    endfunction

    // A line starts one edge after acceptance, or right after the previous
    // line's last word, whichever is later. A request waiting while the
    // previous line finishes is popped with that last word; otherwise it is
    // popped together with its first word.
    function automatic void record_accept(input int a, input logic [AB-1:0] addr);
        int start;
        start = (a + 1 > last_start + W) ? a + 1 : last_start + W;
        acc_line[n_req]  = addr[AB-1:WIB];
        acc_edge[n_req]  = a;
        acc_start[n_req] = start;
        pop_edge[n_req]  = (a + 1 < start) ? start - 1 : start;
        last_start       = start;
        n_req++;
    endfunction

    int fe_idx, fe_gcyc, fe_wcyc;
    logic [31:0] fe_got, fe_want;

    // Number of returned words in this test that differ from the model in time or data.
    function automatic int stream_errors(input int l);
        int errs = 0;
        fe_idx = -1;
        for (int r = req_base; r < n_req; r++) begin
            for (int k = 0; k < W; k++) begin
                int i;
                int wcyc;
                logic [31:0] want;
                i    = obs_base[l] + (r - req_base) * W + k;
                wcyc = acc_start[r] + k + lat_of(l);
                want = mem_fn({acc_line[r], WIB'(k)});
                if (i >= obs_n[l] || obs_cyc[l][i] != wcyc || obs_dat[l][i] !== want) begin
                    if (fe_idx < 0) begin
                        fe_idx  = i - obs_base[l];
                        fe_gcyc = (i < obs_n[l]) ? obs_cyc[l][i] : -1;
                        fe_got  = (i < obs_n[l]) ? obs_dat[l][i] : 32'h0;
                        fe_wcyc = wcyc;
                        fe_want = want;
                    end
                    errs++;
                end
            end
        end
        return errs;
    endfunction

    task automatic begin_test();
        req_base = n_req;
        wr_bad   = 0;
        for (int l = 0; l < NL; l++) obs_base[l] = obs_n[l];
    endtask

    // Present requests in order, holding each until the model says it is accepted.
    task automatic drive_reqs(input int n);
        for (int r = 0; r < n; r++) begin
            bit done;
            repeat (req_gap[r]) @(negedge clock);
            imem_address = req_addr[r];
            imem_read    = 1'b1;
            done         = 1'b0;
            for (int t = 0; t < 200 && !done; t++) begin
                bit exp_full;
                exp_full = (occupancy(cyc) == DEPTH);
                for (int l = 0; l < NL; l++) if (wr[l] !== exp_full) wr_bad++;
                if (exp_full) model_waits++;
                else begin
                    record_accept(cyc + 1, req_addr[r]);
                    done = 1'b1;
                end
                @(negedge clock);
            end
            if (!done) wr_bad++;
            imem_read = 1'b0;
        end
    endtask

    task automatic drain();
        while (cyc < last_start + W + 8) @(negedge clock);
    endtask

    task automatic apply_reset();
        imem_read    = 1'b0;
        imem_address = '0;
        reset_n      = 1'b0;
        n_req        = 0;
        last_start   = -1000;
        model_waits  = 0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    // Stream, count, latency and perf comparisons shared by the traffic tests' bodies.
    task automatic check_traffic(input string name);
        int errs;
        int nexp;
        n_checks++;
        if (wr_bad !== 0) $display("FAIL %s waitrequest: %0d cycles differ from model, want 0", name, wr_bad);
        else n_pass++;
        nexp = (n_req - req_base) * W;
        for (int l = 0; l < NL; l++) begin
            n_checks++;
            if (obs_n[l] - obs_base[l] !== nexp)
                $display("FAIL %s word count lat%0d: got %0d want %0d", name, lat_of(l), obs_n[l] - obs_base[l], nexp);
            else n_pass++;
            errs = stream_errors(l);
            n_checks++;
            if (errs !== 0)
                $display("FAIL %s stream lat%0d: %0d bad words, first #%0d got %h@%0d want %h@%0d",
                         name, lat_of(l), errs, fe_idx, fe_got, fe_gcyc, fe_want, fe_wcyc);
            else n_pass++;
            n_checks++;
            if (pb[l] !== (PERF_ON ? 32'(n_req) : 32'd0))
                $display("FAIL %s perf_bursts lat%0d: got %0d want %0d", name, lat_of(l), pb[l], PERF_ON ? n_req : 0);
            else n_pass++;
        end
        n_checks++;
        if (pw[0] !== (PERF_ON ? 32'(model_waits) : 32'd0))
            $display("FAIL %s perf_wait_cycles: got %0d want %0d", name, pw[0], PERF_ON ? model_waits : 0);
        else n_pass++;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if (wr[0] !== 1'b0) $display("FAIL reset waitrequest: got %b want 0", wr[0]); else n_pass++;
        n_checks++;
        if (rdv[0] !== 1'b0) $display("FAIL reset readdatavalid: got %b want 0", rdv[0]); else n_pass++;
        n_checks++;
        if (mread[0] !== 1'b0) $display("FAIL reset mem_read: got %b want 0", mread[0]); else n_pass++;
        n_checks++;
        if (maddr[0] !== '0) $display("FAIL reset mem_address: got %h want 0", maddr[0]); else n_pass++;
        n_checks++;
        if (pb[0] !== 32'd0 || pw[0] !== 32'd0)
            $display("FAIL reset perf: got %0d/%0d want 0/0", pb[0], pw[0]);
        else n_pass++;
    endtask

    task automatic test_single();
        begin_test();
        req_addr[0] = 30'h40; req_gap[0] = 0;
        drive_reqs(1);
        drain();
        // First word 1+latency edges after acceptance.
        for (int l = 0; l < NL; l++) begin
            n_checks++;
            if (obs_n[l] == obs_base[l] || obs_cyc[l][obs_base[l]] - acc_edge[req_base] !== 1 + lat_of(l))
                $display("FAIL single first-valid lat%0d: got %0d want %0d cycles after accept", lat_of(l),
                         (obs_n[l] == obs_base[l]) ? -1 : obs_cyc[l][obs_base[l]] - acc_edge[req_base], 1 + lat_of(l));
            else n_pass++;
        end
        check_traffic("single");
    endtask

    task automatic test_misaligned();
        begin_test();
        req_addr[0] = 30'h47; req_gap[0] = 0;
        drive_reqs(1);
        drain();
        check_traffic("misaligned");
    endtask

    task automatic test_back_to_back();
        begin_test();
        req_addr[0] = 30'h00;  req_gap[0] = 0;
        req_addr[1] = 30'h20;  req_gap[1] = 0;
        req_addr[2] = 30'h80;  req_gap[2] = 0;
        req_addr[3] = 30'h1E5; req_gap[3] = 0;
        drive_reqs(4);
        drain();
        check_traffic("back_to_back");
    endtask

    task automatic test_top_line();
        begin_test();
        req_addr[0] = 30'h3FFFFFE0; req_gap[0] = 0;
        drive_reqs(1);
        drain();
        check_traffic("top_line");
    endtask

    task automatic test_reset_mid_burst();
        int seen;
        begin_test();
        req_addr[0] = 30'h200; req_gap[0] = 0;
        drive_reqs(1);
        for (int t = 0; t < 100 && obs_n[0] - obs_base[0] < 10; t++) begin
            @(negedge clock);
            #1;
        end
        n_checks++;
        if (obs_n[0] - obs_base[0] !== 10 || rdv[0] !== 1'b1)
            $display("FAIL midreset reach word 10: got %0d words valid=%b want 10 valid=1", obs_n[0] - obs_base[0], rdv[0]);
        else n_pass++;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (rdv[0] !== 1'b0 || rdv[1] !== 1'b0 || rdv[2] !== 1'b0 || mread[0] !== 1'b0)
            $display("FAIL midreset async clear: got valids %b%b%b mem_read %b want 0000", rdv[0], rdv[1], rdv[2], mread[0]);
        else n_pass++;
        n_req       = 0;
        last_start  = -1000;
        model_waits = 0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        n_checks++;
        if (wr[0] !== 1'b0) $display("FAIL midreset waitrequest: got %b want 0", wr[0]); else n_pass++;
        seen = obs_n[0];
        repeat (40) @(negedge clock);
        n_checks++;
        if (obs_n[0] !== seen) $display("FAIL midreset residual valids: got %0d want 0", obs_n[0] - seen);
        else n_pass++;
        begin_test();
        req_addr[0] = 30'h100; req_gap[0] = 0;
        drive_reqs(1);
        drain();
        check_traffic("after_reset");
    endtask

    task automatic test_random();
        begin_test();
        for (int r = 0; r < 8; r++) begin
            req_addr[r] = AB'($urandom());
            req_gap[r]  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 40)) : 0;
        end
        drive_reqs(8);
        drain();
        check_traffic("random");
    endtask

    initial begin
        reset_n      = 1'b0;
        imem_read    = 1'b0;
        imem_address = '0;
        for (int l = 0; l < NL; l++) obs_base[l] = 0;
        test_reset();
        test_single();
        test_misaligned();
        test_back_to_back();
        test_top_line();
        test_reset_mid_burst();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
